// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the fetch/data unified-memory port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int unsigned STREAK_W = 4;

  // Saturating increment of the data-side streak counter.
  function automatic logic [STREAK_W-1:0] streakInc(input logic [STREAK_W-1:0] cur,
                                                     input logic [STREAK_W-1:0] maxVal);
    return (cur < maxVal) ? cur + STREAK_W'(1) : maxVal;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: data side wins unless fetch is waiting and the data streak is saturated.
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_if,
  output logic                grant_dm
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  always_comb begin
    grant_dm = dm_req & (~if_req | (streak < STREAK_MAX));
    grant_if = if_req & ~grant_dm;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between the fetch and data-memory pipeline stages.
// Each access runs IDLE -> BUSY_x -> RESP, so the requester sees a one-cycle ready pulse.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_dm
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_t          stateQ, stateNext;
  logic [STREAK_W-1:0] streakQ, streakNext;
  logic                ownerQ, ownerNext;
  logic                grantIf, grantDm;

  logic                memReqNext, memWeNext;
  logic [ADDR_W-1:0]   memAddrNext;
  logic [DATA_W-1:0]   memWdataNext;
  logic [DATA_W-1:0]   ifRdataNext, dmRdataNext;
  logic                ifReadyNext, dmReadyNext;

  mem_arb_pick #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) uPick (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .streak  (streakQ),
    .grant_if(grantIf),
    .grant_dm(grantDm)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateNext;
  end

  // Next state and next values of every registered output
  always_comb begin
    stateNext    = stateQ;
    streakNext   = streakQ;
    ownerNext    = ownerQ;
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    ifRdataNext  = if_rdata;
    dmRdataNext  = dm_rdata;
    ifReadyNext  = 1'b0;
    dmReadyNext  = 1'b0;

    case (stateQ)
      IDLE: begin
        if (grantDm) begin
          stateNext    = BUSY_DM;
          ownerNext    = OWN_DM;
          memReqNext   = 1'b1;
          memWeNext    = dm_we;
          memAddrNext  = dm_addr;
          memWdataNext = dm_wdata;
          // Only data grants that actually overtake a waiting fetch count toward the streak
          streakNext   = if_req ? streakInc(streakQ, STREAK_MAX) : '0;
        end else if (grantIf) begin
          stateNext    = BUSY_IF;
          ownerNext    = OWN_IF;
          memReqNext   = 1'b1;
          memWeNext    = 1'b0;
          memAddrNext  = if_addr;
          memWdataNext = '0;
          streakNext   = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          stateNext  = RESP;
          memReqNext = 1'b0;
          if (ownerQ == OWN_DM) begin
            dmReadyNext = 1'b1;
            if (!mem_we) dmRdataNext = mem_rdata;
          end else begin
            ifReadyNext = 1'b1;
            ifRdataNext = mem_rdata;
          end
        end
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streakQ   <= '0;
      ownerQ    <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      streakQ   <= streakNext;
      ownerQ    <= ownerNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      if_rdata  <= ifRdataNext;
      dm_rdata  <= dmRdataNext;
      if_ready  <= ifReadyNext;
      dm_ready  <= dmReadyNext;
    end
  end

  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;

endmodule
